// File: rtl/starfield_capture.sv
// starfield_capture: samples the starfield generator's per-pixel stream in
// lockstep with its enable, queues every qualifying star as an (x, y,
// brightness) record in a small FIFO, and keeps per-frame star counts.
module starfield_capture #(
  parameter int         H          = 800,
  parameter int         V          = 525,
  parameter int         CORDW      = 10,
  parameter int         DEPTH      = 16,
  parameter logic [7:0] MIN_BRIGHT = 8'd0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sof_i,
  input  logic             clr_i,
  input  logic             sf_on_i,
  input  logic [7:0]       sf_star_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CORDW-1:0] out_x_o,
  output logic [CORDW-1:0] out_y_o,
  output logic [7:0]       out_star_o,
  output logic [15:0]      stars_last_o,
  output logic             frame_done_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 2 * CORDW + 8;
  localparam logic [CORDW-1:0] XLast = CORDW'(H - 1);
  localparam logic [CORDW-1:0] YLast = CORDW'(V - 1);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [CORDW-1:0] x_q, x_d, y_q, y_d;
  logic [15:0]      frameCnt_q, frameCnt_d, starsLast_q, starsLast_d, cntInc;
  logic             frameDone_q, frameDone_d, overflow_q, overflow_d;
  logic [RW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic [8:0]       brightDiff;
  logic             qualify, frameEnd, full, empty, pop, accept, drop;
  logic [CORDW-1:0] recX, recY;
  logic [RW-1:0]    pushRec, headRec;

  // Qualify the current pixel and build its record; a sof pixel is logged as (0,0).
  always_comb begin
    brightDiff = {1'b0, sf_star_i} - {1'b0, MIN_BRIGHT};
    qualify    = en_i & sf_on_i & ~brightDiff[8];
    frameEnd   = en_i & ~sof_i & (x_q == XLast) & (y_q == YLast);
    recX       = sof_i ? '0 : x_q;
    recY       = sof_i ? '0 : y_q;
    pushRec    = {recX, recY, sf_star_i};
    empty      = (count_q == '0);
    full       = (count_q == FullCount);
    pop        = ~empty & out_ready_i;
    accept     = qualify & (~full | pop);
    drop       = qualify & full & ~pop;
  end

  // Raster position: sof forces the origin, otherwise advance with wrap.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (sof_i) begin
      x_d = en_i ? CORDW'(1) : '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + CORDW'(1);
      end else begin
        x_d = x_q + CORDW'(1);
      end
    end
  end

  // Per-frame star count (saturating), frame-end publication and sticky overflow.
  always_comb begin
    cntInc      = (qualify && frameCnt_q != 16'hFFFF) ? frameCnt_q + 16'd1 : frameCnt_q;
    frameCnt_d  = frameCnt_q;
    starsLast_d = starsLast_q;
    frameDone_d = 1'b0;
    if (sof_i) begin
      frameCnt_d = {15'd0, qualify};
    end else if (frameEnd) begin
      starsLast_d = cntInc;
      frameDone_d = 1'b1;
      frameCnt_d  = '0;
    end else if (en_i) begin
      frameCnt_d = cntInc;
    end
    overflow_d = drop ? 1'b1 : (clr_i ? 1'b0 : overflow_q);
  end

  // FIFO pointer and occupancy bookkeeping; pop and push may share a cycle even when full.
  always_comb begin
    wrPtr_d = accept ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d = pop ? rdPtr_q + AW'(1) : rdPtr_q;
    count_d = count_q;
    if (accept && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!accept && pop) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  // State registers; reset discards the queue and any frame in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q         <= '0;
      y_q         <= '0;
      frameCnt_q  <= '0;
      starsLast_q <= '0;
      frameDone_q <= 1'b0;
      overflow_q  <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frameCnt_q  <= frameCnt_d;
      starsLast_q <= starsLast_d;
      frameDone_q <= frameDone_d;
      overflow_q  <= overflow_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
    end
  end

  // Record storage; contents only matter behind the occupancy count, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[wrPtr_q] <= pushRec;
    end
  end

  // Head record is forced to zero while empty so a reset clears every output.
  always_comb begin
    headRec                            = empty ? '0 : mem_q[rdPtr_q];
    {out_x_o, out_y_o, out_star_o}     = headRec;
    out_valid_o                        = ~empty;
    stars_last_o                       = starsLast_q;
    frame_done_o                       = frameDone_q;
    overflow_o                         = overflow_q;
  end

endmodule

// File: doc/starfield_capture.md
# starfield_capture

Consumer-side companion to the starfield generator: watches the per-pixel star stream (`sf_on`, `sf_star`) in lockstep with the generator's enable and logs every qualifying star as an (x, y, brightness) record. Records go into a small FIFO that downstream logic (sprite placement, frame checker, debug readout) drains with a valid/ready handshake. Also counts stars per frame and flags dropped records.

## Interface
- `H`, default 800: pixels per line, counting positions.
- `V`, default 525: lines per frame.
- `CORDW`, default 10: coordinate width; must satisfy 2^CORDW ≥ max(H, V).
- `DEPTH`, default 16: FIFO entries, power of two, ≥ 2.
- `MIN_BRIGHT`, default 8'd0: a star is captured only if `sf_star ≥ MIN_BRIGHT`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: pixel advance; the same enable that drives the generator.
- `sof` in 1: start-of-frame resync.
- `clr` in 1: synchronous clear of the `overflow` flag.
- `sf_on` in 1: star present at the current pixel.
- `sf_star` in 8: star brightness.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_x` out CORDW: head record x.
- `out_y` out CORDW: head record y.
- `out_star` out 8: head record brightness.
- `stars_last` out 16: star count of the last completed frame.
- `frame_done` out 1: one-cycle pulse when `stars_last` updates.
- `overflow` out 1: sticky flag, set when a record is dropped.

## Operation
- **Position counters `x`, `y`.** Reset to (0,0). When `en`=1 the current pixel is sampled, then x increments. At x=H-1, x wraps to 0 and y increments. At (H-1, V-1), the position wraps to (0,0).
- **`sof` resync.**
  - `sof`=1 and `en`=0: the position becomes (0,0) and the frame count clears. Nothing is published.
  - `sof`=1 and `en`=1: the current pixel is treated as (0,0), the position becomes (1,0), and the frame count restarts at this pixel's contribution (0 or 1). Nothing is published.
  - `sof` has priority over wrap logic.
- **Qualify.** A pixel qualifies when `en` and `sf_on` and `sf_star ≥ MIN_BRIGHT`. A qualifying pixel produces record {x, y, sf_star} and increments the frame count. The frame count saturates at 16'hFFFF.
- **Frame end.** On the `en` cycle at (H-1, V-1) with no `sof`:
  - `stars_last` takes the frame count, including this pixel.
  - `frame_done` pulses on the following cycle.
  - The frame count restarts at 0.
- **FIFO.** DEPTH entries, first-in first-out. The head is presented on `out_*` with `out_valid`=1 whenever the FIFO is non-empty.
  - A pop occurs when `out_valid` and `out_ready` are both 1.
  - Push and pop in the same cycle is always legal, including when the FIFO is full: the pop frees the slot and the push is accepted.
  - Push to a full FIFO with no pop: the record is dropped, the FIFO is unchanged, and `overflow` is set.
  - The frame count still includes dropped stars.
- **`overflow`.** Cleared only by reset or by `clr`=1. If set and clear occur in the same cycle, the set wins.
- `out_ready` while empty: no effect.

## Timing
- **Reset values.** All outputs are 0, the FIFO is empty, the position is (0,0) and the frame count is 0. `rst_n` low mid-frame aborts immediately: FIFO contents are lost and no `frame_done` is issued.
- **Capture latency.** A qualifying pixel on cycle N appears at the FIFO head with `out_valid`=1 on cycle N+1 if the FIFO was empty.
- **Pop.** A pop on cycle N exposes the next entry, or `out_valid`=0, on cycle N+1.
- **Output stability.** `out_x`/`out_y`/`out_star` are stable while `out_valid`=1 and `out_ready`=0. They are don't-care when `out_valid`=0.
- **Frame pulse.** `stars_last` and `frame_done` update one cycle after the final pixel of the frame is sampled.
- **Throughput.** Sustains one capture per cycle with `out_ready` held high. With `en` held high and no stall, at most 0 drops.
- **No pipelined inputs.** `sf_on`/`sf_star` are sampled in the same cycle as `en`; the generator's outputs are already aligned to its counter.

## Test plan
- **Basic capture, H=4, V=3.** `en` held 1 from reset; stars at pixel indices 1 (`sf_star`=8'h40) and 6 (`sf_star`=8'hA0); `out_ready`=1.
  - Records (1,0,40) and (2,1,A0) each appear one cycle after sampling.
  - After pixel 11: `stars_last`=2 and a single `frame_done` pulse.
- **Threshold, MIN_BRIGHT=8'h80.** Stars of 8'h7F and 8'h80.
  - Only the 8'h80 star is captured and counted.
- **Overflow, DEPTH=4, `out_ready`=0.** Six consecutive stars.
  - First four are held and `overflow`=1.
  - `stars_last`=6 at frame end.
  - Raising `out_ready` drains the four in order.
  - `clr` then clears `overflow`.
- **Full with simultaneous pop.** FIFO full, `out_ready`=1, star arrives.
  - Record accepted, `overflow` stays 0, occupancy stays 4.
- **`sof` mid-frame.** At position (2,1): `sof`=1 with `en`=1 and a star present.
  - Record (0,0,…) is captured and the position becomes (1,0).
  - No `frame_done`; the next `stars_last` counts from this pixel.
- **Async reset mid-frame.** Drop `rst_n` with 3 entries queued and the position at (3,2).
  - Immediately `out_valid`=0, all outputs 0.
  - After release, capture restarts at (0,0).
